// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping circularly.
module rr_pick #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [NUM_M-1:0] masked;
    logic [NUM_M-1:0] cand;

    always_comb begin
        masked  = '0;
        gnt     = '0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            masked[i] = req[i] && (i >= 32'(ptr));
        end
        // Masked requests win; with none at or above ptr, wrap to the full request set.
        cand = (|masked) ? masked : req;
        any  = |req;
        // Walk downwards so the lowest set candidate is the last assignment.
        for (int i = int'(NUM_M) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt     = NUM_M'(1) << i;
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave port among NUM_M masters,
// one complete write or read transaction at a time.
module axi_lite_rr_arbiter #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_M*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_M-1:0]            m_awvalid,
    output logic [NUM_M-1:0]            m_awready,
    input  logic [NUM_M*DATA_W-1:0]     m_wdata,
    input  logic [NUM_M*(DATA_W/8)-1:0] m_wstrb,
    input  logic [NUM_M-1:0]            m_wvalid,
    output logic [NUM_M-1:0]            m_wready,
    output logic [NUM_M*2-1:0]          m_bresp,
    output logic [NUM_M-1:0]            m_bvalid,
    input  logic [NUM_M-1:0]            m_bready,
    input  logic [NUM_M*ADDR_W-1:0]     m_araddr,
    input  logic [NUM_M-1:0]            m_arvalid,
    output logic [NUM_M-1:0]            m_arready,
    output logic [NUM_M*DATA_W-1:0]     m_rdata,
    output logic [NUM_M*2-1:0]          m_rresp,
    output logic [NUM_M-1:0]            m_rvalid,
    input  logic [NUM_M-1:0]            m_rready,
    output logic [ADDR_W-1:0]           s_axi_awaddr,
    output logic                        s_axi_awvalid,
    input  logic                        s_axi_awready,
    output logic [DATA_W-1:0]           s_axi_wdata,
    output logic [DATA_W/8-1:0]         s_axi_wstrb,
    output logic                        s_axi_wvalid,
    input  logic                        s_axi_wready,
    input  logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_bvalid,
    output logic                        s_axi_bready,
    output logic [ADDR_W-1:0]           s_axi_araddr,
    output logic                        s_axi_arvalid,
    input  logic                        s_axi_arready,
    input  logic [DATA_W-1:0]           s_axi_rdata,
    input  logic [1:0]                  s_axi_rresp,
    input  logic                        s_axi_rvalid,
    output logic                        s_axi_rready,
    output logic [$clog2(NUM_M)-1:0]    grant_id,
    output logic                        busy
);

    import axi_lite_arb_pkg::*;

    localparam int unsigned IDX_W  = $clog2(NUM_M);
    localparam int unsigned STRB_W = DATA_W / 8;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             pick_write;
    logic [NUM_M-1:0] gsel;
    logic [IDX_W-1:0] next_ptr;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign req = (m_awvalid & m_wvalid) | m_arvalid;

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // A master with both a write and a read pending is served the write first.
    always_comb begin
        pick_write = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (pick_gnt[i]) pick_write = m_awvalid[i] & m_wvalid[i];
        end
    end

    assign gsel     = NUM_M'(1) << grant_q;
    assign next_ptr = (grant_q == IDX_W'(NUM_M - 1)) ? '0 : grant_q + IDX_W'(1);

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign b_hs  = s_axi_bvalid & s_axi_bready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = s_axi_rvalid & s_axi_rready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = pick_write ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            // The pointer advances only on completion, so a long transaction keeps its turn.
            WR_RESP: begin
                if (b_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            RD_ADDR: begin
                if (ar_hs) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_awready     = '0;
        m_wready      = '0;
        m_bresp       = {NUM_M{RESP_OKAY}};
        m_bvalid      = '0;
        m_arready     = '0;
        m_rdata       = '0;
        m_rresp       = {NUM_M{RESP_OKAY}};
        m_rvalid      = '0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        grant_id      = grant_q;
        busy          = (state_q != IDLE);
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (gsel[i]) begin
                case (state_q)
                    WR_ADDR: begin
                        s_axi_awaddr  = m_awaddr[i*ADDR_W +: ADDR_W];
                        s_axi_awvalid = m_awvalid[i] & ~aw_done_q;
                        m_awready[i]  = s_axi_awready & ~aw_done_q;
                        s_axi_wdata   = m_wdata[i*DATA_W +: DATA_W];
                        s_axi_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
                        s_axi_wvalid  = m_wvalid[i] & ~w_done_q;
                        m_wready[i]   = s_axi_wready & ~w_done_q;
                    end
                    WR_RESP: begin
                        s_axi_bready     = m_bready[i];
                        m_bvalid[i]      = s_axi_bvalid;
                        m_bresp[i*2 +: 2] = s_axi_bresp;
                    end
                    RD_ADDR: begin
                        s_axi_araddr  = m_araddr[i*ADDR_W +: ADDR_W];
                        s_axi_arvalid = m_arvalid[i];
                        m_arready[i]  = s_axi_arready;
                    end
                    RD_RESP: begin
                        s_axi_rready               = m_rready[i];
                        m_rvalid[i]                = s_axi_rvalid;
                        m_rdata[i*DATA_W +: DATA_W] = s_axi_rdata;
                        m_rresp[i*2 +: 2]          = s_axi_rresp;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
